// File: rtl/updown_game_ctrl.sv
// updown_game_ctrl: round controller for the up/down guessing game
//   clk, rst       - clock, synchronous active-high reset
//   start          - pulse, begins (or aborts into) a new round
//   submit, result - guess commit pulse and comparator verdict (00 ok, 01 up, 10 down, 11 illegal)
//   rng_value      - free-running random value, captured in the load cycle
//   actual_number  - latched secret driven to the comparator
//   attempts, hint - guesses used this round, last wrong-direction verdict (11 = none yet)
//   playing, win, lose - registered one-hot round status
module updown_game_ctrl #(
    parameter int MAX_NUM   = 99,
    parameter int MAX_TRIES = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       submit,
    input  logic [1:0] result,
    input  logic [6:0] rng_value,
    output logic [6:0] actual_number,
    output logic [3:0] attempts,
    output logic [1:0] hint,
    output logic       playing,
    output logic       win,
    output logic       lose
);
    typedef enum logic [2:0] {IDLE, LOAD, PLAY, WIN, LOSE} state_t;
    state_t     state_q;
    logic [6:0] secret_q;
    logic [3:0] att_q;
    logic [1:0] hint_q;
    logic       playing_q, win_q, lose_q;
    logic [3:0] att_d;
    logic [6:0] secret_d;
    assign att_d = att_q + 4'd1;
    // rng_value never exceeds 2*(MAX_NUM+1)-1, so one conditional subtraction folds it into range
    assign secret_d = (rng_value <= 7'(MAX_NUM)) ? rng_value : rng_value - 7'(MAX_NUM + 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            secret_q  <= '0;
            att_q     <= '0;
            hint_q    <= 2'b11;
            playing_q <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) state_q <= LOAD;
                LOAD: begin
                    secret_q  <= secret_d;
                    att_q     <= '0;
                    hint_q    <= 2'b11;
                    state_q   <= PLAY;
                    playing_q <= 1'b1;
                end
                PLAY: begin
                    if (start) begin
                        state_q   <= LOAD;
                        playing_q <= 1'b0;
                    end else if (submit && result != 2'b11) begin
                        att_q <= att_d;
                        if (result == 2'b00) begin
                            state_q   <= WIN;
                            playing_q <= 1'b0;
                            win_q     <= 1'b1;
                        end else begin
                            hint_q <= result;
                            // a correct guess is handled above, so the last try can still win
                            if (att_d == 4'(MAX_TRIES)) begin
                                state_q   <= LOSE;
                                playing_q <= 1'b0;
                                lose_q    <= 1'b1;
                            end
                        end
                    end
                end
                WIN, LOSE: if (start) begin
                    state_q <= LOAD;
                    win_q   <= 1'b0;
                    lose_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign actual_number = secret_q;
    assign attempts      = att_q;
    assign hint          = hint_q;
    assign playing       = playing_q;
    assign win           = win_q;
    assign lose          = lose_q;
endmodule

// File: tb/tb_updown_game_ctrl.sv
// tb_updown_game_ctrl: randomized and directed scoreboard bench for updown_game_ctrl
module tb_updown_game_ctrl;
    localparam int MAX_NUM   = 99;
    localparam int MAX_TRIES = 7;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       submit = 1'b0;
    logic [1:0] result = 2'b00;
    logic [6:0] rng_value = '0;
    logic [6:0] actual_number;
    logic [3:0] attempts;
    logic [1:0] hint_o;
    logic       playing, win, lose;
    updown_game_ctrl #(.MAX_NUM(MAX_NUM), .MAX_TRIES(MAX_TRIES)) dut (
        .clk(clk), .rst(rst), .start(start), .submit(submit), .result(result),
        .rng_value(rng_value), .actual_number(actual_number), .attempts(attempts),
        .hint(hint_o), .playing(playing), .win(win), .lose(lose)
    );
    always #5 clk = ~clk;
    typedef struct {
        int an;
        int at;
        int h;
        int p;
        int w;
        int l;
    } exp_t;
    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;
    // round model: a pending load, whether a round is live, and how it ended
    bit m_load = 0, m_live = 0, m_won = 0, m_lost = 0;
    int m_secret = 0, m_tries = 0, m_hint = 3;
    task automatic model(input bit r, input bit s, input bit sb, input int res, input int rv);
        if (r) begin
            m_load = 0; m_live = 0; m_won = 0; m_lost = 0;
            m_secret = 0; m_tries = 0; m_hint = 3;
        end else if (m_load) begin
            m_secret = rv % (MAX_NUM + 1);
            m_tries = 0; m_hint = 3;
            m_load = 0; m_live = 1;
        end else if (s) begin
            m_load = 1; m_live = 0; m_won = 0; m_lost = 0;
        end else if (m_live && sb && res != 3) begin
            m_tries++;
            if (res == 0) begin
                m_won = 1; m_live = 0;
            end else begin
                m_hint = res;
                if (m_tries == MAX_TRIES) begin
                    m_lost = 1; m_live = 0;
                end
            end
        end
    endtask
    task automatic step(input bit r, input bit s, input bit sb, input int res, input int rv);
        exp_t e;
        @(negedge clk);
        rst = r; start = s; submit = sb; result = 2'(res); rng_value = 7'(rv);
        model(r, s, sb, res, rv);
        e.an = m_secret; e.at = m_tries; e.h = m_hint;
        e.p = m_live; e.w = m_won; e.l = m_lost;
        exp_q.push_back(e);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, $urandom_range(127));
    endtask
    task automatic sub(input int res);
        step(0, 0, 1, res, $urandom_range(127));
    endtask
    task automatic start_round(input int rv);
        step(0, 1, 0, 0, $urandom_range(127));
        step(0, 0, 0, 0, rv);
    endtask
    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("actual_number", int'(actual_number), e.an);
            chk("attempts", int'(attempts), e.at);
            chk("hint", int'(hint_o), e.h);
            chk("playing", int'(playing), e.p);
            chk("win", int'(win), e.w);
            chk("lose", int'(lose), e.l);
            chk("onehot_status", int'(playing) + int'(win) + int'(lose) <= 1 ? 1 : 0, 1);
        end
    end
    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        sub(2);
        start_round(42);
        sub(2); sub(1); sub(0);
        idle(2);
        sub(1);
        sub(3);
        start_round(115);
        for (int i = 0; i < MAX_TRIES; i++) sub(1);
        sub(2);
        start_round($urandom_range(127));
        for (int i = 0; i < MAX_TRIES - 1; i++) sub($urandom_range(1, 2));
        sub(0);
        start_round($urandom_range(127));
        sub(3);
        sub(1);
        sub(3);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 77);
        sub(2);
        sub(1);
        step(1, 0, 1, 1, 0);
        sub(1);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 100);
        start_round(127);
        sub(1); sub(1);
        for (int i = 0; i < 1500; i++)
            step($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(2) == 0,
                 $urandom_range(3), $urandom_range(127));
        idle(2);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
